// File: rtl/add_pkg.sv
// Shared constants for the nibble-serial adder sequencer: FSM codes and slice width.
package add_pkg;
    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/fa4_mbit.sv
// 4-bit ripple-carry adder slice built from full-adder cells.
module fa4_mbit (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[4];
endmodule

// File: rtl/add_seq_ctrl.sv
// Sequencer that performs one WIDTH-bit addition by running a shared 4-bit
// slice once per cycle, least-significant nibble first, with a registered carry.
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] sum4;
    logic               c_next;

    assign a_nib = a_r[SLICE_W*idx +: SLICE_W];
    assign b_nib = b_r[SLICE_W*idx +: SLICE_W];

    fa4_mbit u_slice (
        .s  (sum4),
        .co (c_next),
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_r)
    );

    // Outputs decode the state register only, so nothing combinational reaches them from inputs.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ci;
                        s       <= '0;
                        co      <= 1'b0;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s[SLICE_W*idx +: SLICE_W] <= sum4;
                    carry_r                   <= c_next;
                    // idx holds at the last slice instead of wrapping.
                    if (idx == IDX_LAST) begin
                        co    <= c_next;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: WIDTH=16 and WIDTH=4 instances against a transaction-level model.
module tb_add_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [15:0] a         [2];
    logic [15:0] b         [2];
    logic        ci        [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        co        [2];
    logic        busy      [2];
    logic [15:0] s16;
    logic [3:0]  s4;
    logic [15:0] s_o       [2];

    assign s_o[0] = s16;
    assign s_o[1] = {12'b0, s4};

    add_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .a(a[0]), .b(b[0]), .ci(ci[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .s(s16), .co(co[0]), .busy(busy[0])
    );

    add_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .a(a[1][3:0]), .b(b[1][3:0]), .ci(ci[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .s(s4), .co(co[1]), .busy(busy[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction model: a request is in flight from acceptance until its result is taken;
    // the result becomes visible once the slice count of edges has elapsed.
    bit          m_in  [2];
    int          m_age [2];
    logic [16:0] m_exp [2];
    int          n_acc [2];
    int          n_dut_rsp [2];

    function automatic int nsl(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [15:0] exp_s(input int i);
        return (i == 0) ? m_exp[i][15:0] : {12'b0, m_exp[i][3:0]};
    endfunction

    function automatic logic exp_co(input int i);
        return (i == 0) ? m_exp[i][16] : m_exp[i][4];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_in[i]  = 1'b0;
                m_age[i] = 0;
            end else if (m_in[i]) begin
                if (m_age[i] >= nsl(i) && rsp_ready[i]) m_in[i] = 1'b0;
                else if (m_age[i] < nsl(i)) m_age[i]++;
            end else if (req_valid[i]) begin
                m_in[i]  = 1'b1;
                m_age[i] = 0;
                n_acc[i]++;
                if (i == 0) m_exp[i] = {1'b0, a[i]} + {1'b0, b[i]} + {16'b0, ci[i]};
                else        m_exp[i] = {13'b0, a[i][3:0]} + {13'b0, b[i][3:0]} + {16'b0, ci[i]};
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++)
                if (rsp_valid[i] && rsp_ready[i]) n_dut_rsp[i]++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("req_ready[%0d]", i), {31'b0, req_ready[i]}, {31'b0, !m_in[i]});
            chk($sformatf("busy[%0d]", i), {31'b0, busy[i]}, {31'b0, m_in[i]});
            chk($sformatf("rsp_valid[%0d]", i), {31'b0, rsp_valid[i]},
                {31'b0, m_in[i] && m_age[i] >= nsl(i)});
            if (m_in[i] && m_age[i] >= nsl(i)) begin
                chk($sformatf("s[%0d]", i), {16'b0, s_o[i]}, {16'b0, exp_s(i)});
                chk($sformatf("co[%0d]", i), {31'b0, co[i]}, {31'b0, exp_co(i)});
            end else if (m_in[i]) begin
                chk($sformatf("run_unwritten[%0d]", i), {16'b0, s_o[i] >> (4 * m_age[i])}, 32'd0);
            end
        end
    end

    task automatic send(input int i, input logic [15:0] av, input logic [15:0] bv, input logic c);
        req_valid[i] = 1'b1;
        a[i] = av;
        b[i] = bv;
        ci[i] = c;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int lat);
        lat = 0;
        while (!rsp_valid[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input int i);
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    int lat;
    int acc_before;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
            a[i] = '0; b[i] = '0; ci[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("rst_busy", {31'b0, busy[0]}, 32'd0);
        chk("rst_s", {16'b0, s16}, 32'd0);
        rst = 1'b0;

        // Plain addition and latency
        send(0, 16'h1234, 16'h4321, 1'b0);
        wait_rsp(0, lat);
        chk("t1_latency", lat, 32'd4);
        chk("t1_s", {16'b0, s16}, 32'h5555);
        chk("t1_co", {31'b0, co[0]}, 32'd0);
        take(0);
        chk("t1_ready_after", {31'b0, req_ready[0]}, 32'd1);

        // Carry through all slices
        send(0, 16'hFFFF, 16'h0001, 1'b0);
        wait_rsp(0, lat);
        chk("t2_s", {16'b0, s16}, 32'h0000);
        chk("t2_co", {31'b0, co[0]}, 32'd1);
        take(0);

        // Carry-in, operand changes during RUN ignored, then backpressure
        send(0, 16'h0000, 16'hFFFF, 1'b1);
        a[0] = 16'hAAAA; b[0] = 16'h5555; ci[0] = 1'b0; req_valid[0] = 1'b1;
        wait_rsp(0, lat);
        req_valid[0] = 1'b0;
        chk("t3_latency", lat, 32'd4);
        for (int k = 0; k < 6; k++) begin
            chk("bp_s", {16'b0, s16}, 32'h0000);
            chk("bp_co", {31'b0, co[0]}, 32'd1);
            chk("bp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("bp_ready", {31'b0, req_ready[0]}, 32'd0);
            @(posedge clk); #1;
        end
        take(0);
        chk("bp_ready_after", {31'b0, req_ready[0]}, 32'd1);
        chk("bp_valid_after", {31'b0, rsp_valid[0]}, 32'd0);

        // Reset in the middle of RUN drops the request
        send(0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_partial_s", {16'b0, s16}, 32'h0045);
        acc_before = n_dut_rsp[0];
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
        chk("mid_rst_s", {16'b0, s16}, 32'd0);
        chk("mid_rst_co", {31'b0, co[0]}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready[0]}, 32'd1);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_rsp", n_dut_rsp[0], acc_before);
        n_acc[0] = 0;
        n_dut_rsp[0] = 0;

        // WIDTH=4 single-slice case
        send(1, 16'h000F, 16'h0001, 1'b1);
        wait_rsp(1, lat);
        chk("w4_latency", lat, 32'd1);
        chk("w4_s", {16'b0, s_o[1]}, 32'h1);
        chk("w4_co", {31'b0, co[1]}, 32'd1);
        take(1);
        n_acc[1] = 0;
        n_dut_rsp[1] = 0;

        // Random requests with random response delays on both widths
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 10; k++) begin
                send(i, 16'($urandom), 16'($urandom), 1'($urandom));
                wait_rsp(i, lat);
                chk($sformatf("rnd_latency[%0d]", i), lat, nsl(i));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                take(i);
            end
            chk($sformatf("rnd_count[%0d]", i), n_dut_rsp[i], n_acc[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
